// File: rtl/strobe_gen.sv
// Burst strobe generator: after start, emits count strobes spaced period cycles apart (count 0 = free-run).
// Optional strobes_sent output is compiled in with STROBE_GEN_COUNT_OUT_EN.
module strobe_gen #(
   parameter int PERIOD_W = 8,
   parameter int COUNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [PERIOD_W-1:0] period,
   input  logic [COUNT_W-1:0]  count,
   output logic                strobe_out,
   output logic                busy,
   output logic                done
`ifdef STROBE_GEN_COUNT_OUT_EN
   ,
   output logic [COUNT_W-1:0]  strobes_sent
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [PERIOD_W-1:0] period_lat;
   logic [PERIOD_W-1:0] ivl_cnt;
   logic [COUNT_W-1:0]  rem_cnt;
   logic                free_run;
   logic [PERIOD_W-1:0] period_eff;
   logic                last_strobe;
   logic                launch;

   assign period_eff  = (period == '0) ? PERIOD_W'(1) : period;
   // rem_cnt holds strobes still owed after the one currently on strobe_out
   assign last_strobe = strobe_out && !free_run && (rem_cnt == '0);
   assign launch      = (state == IDLE) && start && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         strobe_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         period_lat <= '0;
         ivl_cnt    <= '0;
         rem_cnt    <= '0;
         free_run   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done       <= 1'b0;
               strobe_out <= 1'b0;
               busy       <= 1'b0;
               if (launch) begin
                  state      <= RUN;
                  busy       <= 1'b1;
                  strobe_out <= 1'b1;
                  period_lat <= period_eff;
                  ivl_cnt    <= period_eff - PERIOD_W'(1);
                  free_run   <= (count == '0);
                  rem_cnt    <= count - COUNT_W'(1);
               end
            end
            RUN: begin
               if (abort) begin
                  state      <= IDLE;
                  strobe_out <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b0;
               end else if (last_strobe) begin
                  state      <= IDLE;
                  strobe_out <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else if (ivl_cnt == '0) begin
                  strobe_out <= 1'b1;
                  ivl_cnt    <= period_lat - PERIOD_W'(1);
                  if (!free_run) rem_cnt <= rem_cnt - COUNT_W'(1);
               end else begin
                  strobe_out <= 1'b0;
                  ivl_cnt    <= ivl_cnt - PERIOD_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               strobe_out <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

`ifdef STROBE_GEN_COUNT_OUT_EN
   // Counts strobes already shown, so a strobe standing in an abort or last cycle is included
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobes_sent <= '0;
      end else if (launch) begin
         strobes_sent <= '0;
      end else if ((state == RUN) && strobe_out) begin
         strobes_sent <= strobes_sent + COUNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_strobe_gen.sv
// Self-checking bench for strobe_gen: directed burst scenarios plus random traffic
// compared against a cycle-arithmetic reference model.
module tb_strobe_gen;
   localparam int PW = 8;
   localparam int CW = 8;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b1;
   logic          start  = 1'b0;
   logic          abort  = 1'b0;
   logic [PW-1:0] period = '0;
   logic [CW-1:0] count  = '0;
   logic          strobe_out;
   logic          busy;
   logic          done;
`ifdef STROBE_GEN_COUNT_OUT_EN
   logic [CW-1:0] strobes_sent;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   strobe_gen #(.PERIOD_W(PW), .COUNT_W(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .period(period),
      .count(count),
      .strobe_out(strobe_out),
      .busy(busy),
      .done(done)
`ifdef STROBE_GEN_COUNT_OUT_EN
      ,
      .strobes_sent(strobes_sent)
`endif
   );

   // Reference model: cycle c (between edge c-1 and edge c) of a burst launched at edge k
   // carries a strobe when d=c-k-1 is a multiple of P and fewer than N strobes came before.
   logic          m_active   = 1'b0;
   int            m_k        = 0;
   int            m_p        = 1;
   int            m_n        = 0;
   int            edge_n     = 0;
   logic          exp_strobe = 1'b0;
   logic          exp_busy   = 1'b0;
   logic          exp_done   = 1'b0;
   logic [CW-1:0] m_sent     = '0;

   function automatic bit f_strobe(int c, int k, int p, int n);
      int d;
      d = c - k - 1;
      return (d >= 0) && (d % p == 0) && ((n == 0) || (d / p < n));
   endfunction

   function automatic int f_last(int k, int p, int n);
      return k + 1 + (n - 1) * p;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active   <= 1'b0;
         edge_n     <= 0;
         exp_strobe <= 1'b0;
         exp_busy   <= 1'b0;
         exp_done   <= 1'b0;
         m_sent     <= '0;
      end else begin
         edge_n <= edge_n + 1;
         if (m_active && exp_strobe) m_sent <= m_sent + 1'b1;
         if (m_active && abort) begin
            m_active <= 1'b0;
            exp_strobe <= 1'b0; exp_busy <= 1'b0; exp_done <= 1'b0;
         end else if (m_active && m_n != 0 && edge_n + 1 > f_last(m_k, m_p, m_n)) begin
            m_active <= 1'b0;
            exp_strobe <= 1'b0; exp_busy <= 1'b0; exp_done <= 1'b1;
         end else if (m_active) begin
            exp_strobe <= f_strobe(edge_n + 1, m_k, m_p, m_n);
            exp_busy <= 1'b1; exp_done <= 1'b0;
         end else if (start && !abort) begin
            m_active <= 1'b1;
            m_k <= edge_n;
            m_p <= (period == '0) ? 1 : int'(period);
            m_n <= int'(count);
            m_sent <= '0;
            exp_strobe <= 1'b1; exp_busy <= 1'b1; exp_done <= 1'b0;
         end else begin
            exp_strobe <= 1'b0; exp_busy <= 1'b0; exp_done <= 1'b0;
         end
      end
   end

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({strobe_out, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=000", {strobe_out, busy, done});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({strobe_out, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release got=%b exp=000", {strobe_out, busy, done});
      end
   endtask

   task automatic test_basic_burst();
      int n_str = 0;
      int done_cyc = -1;
      @(negedge clk);
      start = 1'b1; period = 8'd4; count = 8'd3;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         checks++;
         if ({strobe_out, busy, done} !== {exp_strobe, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL basic_model cyc=%0d sbd got=%b exp=%b", i, {strobe_out, busy, done}, {exp_strobe, exp_busy, exp_done});
         end
         checks++;
         if (strobe_out !== (i == 1 || i == 5 || i == 9)) begin
            errors++;
            $display("FAIL basic_strobe cyc=%0d got=%b", i, strobe_out);
         end
`ifdef STROBE_GEN_COUNT_OUT_EN
         checks++;
         if (strobes_sent !== CW'((i > 1) + (i > 5) + (i > 9))) begin
            errors++;
            $display("FAIL basic_sent cyc=%0d got=%0d exp=%0d", i, strobes_sent, (i > 1) + (i > 5) + (i > 9));
         end
`endif
         if (strobe_out) n_str++;
         if (done) done_cyc = i;
         start = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
         period = 8'($urandom);
         count = 8'($urandom);
      end
      checks++;
      if (n_str != 3 || done_cyc != 10) begin
         errors++;
         $display("FAIL basic_summary strobes=%0d done_cyc=%0d exp 3/10", n_str, done_cyc);
      end
   endtask

   task automatic test_period_zero();
      int done_cyc = -1;
      @(negedge clk);
      start = 1'b1; period = 8'd0; count = 8'd5;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if ({strobe_out, busy, done} !== {exp_strobe, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL p0_model cyc=%0d sbd got=%b exp=%b", i, {strobe_out, busy, done}, {exp_strobe, exp_busy, exp_done});
         end
         checks++;
         if (strobe_out !== (i <= 5)) begin
            errors++;
            $display("FAIL p0_strobe cyc=%0d got=%b exp=%b", i, strobe_out, (i <= 5));
         end
         if (done) done_cyc = i;
      end
      checks++;
      if (done_cyc != 6) begin
         errors++;
         $display("FAIL p0_done got_cyc=%0d exp=6", done_cyc);
      end
   endtask

   task automatic test_free_run_abort();
      int n_str = 0;
      int n_done = 0;
      @(negedge clk);
      start = 1'b1; period = 8'd3; count = 8'd0;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if ({strobe_out, busy, done} !== {exp_strobe, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL free_model cyc=%0d sbd got=%b exp=%b", i, {strobe_out, busy, done}, {exp_strobe, exp_busy, exp_done});
         end
         if (strobe_out) n_str++;
         if (done) n_done++;
         if (i == 21) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL free_abort_idle got busy=%b exp=0", busy);
            end
         end
         abort = (i == 20);
      end
      abort = 1'b0;
      checks++;
      if (n_str != 7 || n_done != 0) begin
         errors++;
         $display("FAIL free_summary strobes=%0d dones=%0d exp 7/0", n_str, n_done);
      end
   endtask

   task automatic test_start_abort_idle();
      int n_str = 0;
      @(negedge clk);
      start = 1'b1; abort = 1'b1; period = 8'd2; count = 8'd2;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      checks++;
      if ({strobe_out, busy} !== 2'b00) begin
         errors++;
         $display("FAIL start_abort_idle got sb=%b exp=00", {strobe_out, busy});
      end
      start = 1'b1; period = 8'd2; count = 8'd4;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         start = (i < 7); period = 8'd9; count = 8'd1;
         checks++;
         if ({strobe_out, busy, done} !== {exp_strobe, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL ignore_model cyc=%0d sbd got=%b exp=%b", i, {strobe_out, busy, done}, {exp_strobe, exp_busy, exp_done});
         end
         checks++;
         if (strobe_out !== (i <= 7 && (i - 1) % 2 == 0)) begin
            errors++;
            $display("FAIL ignore_strobe cyc=%0d got=%b", i, strobe_out);
         end
         if (strobe_out) n_str++;
      end
      start = 1'b0;
      checks++;
      if (n_str != 4) begin
         errors++;
         $display("FAIL ignore_count got=%0d exp=4", n_str);
      end
   endtask

   task automatic test_abort_last();
      @(negedge clk);
      start = 1'b1; period = 8'd2; count = 8'd2;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if ({strobe_out, busy, done} !== {exp_strobe, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL abort_last_model cyc=%0d sbd got=%b exp=%b", i, {strobe_out, busy, done}, {exp_strobe, exp_busy, exp_done});
         end
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_last_done cyc=%0d got=%b exp=0", i, done);
         end
         abort = (i == 3);
      end
      abort = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      start = 1'b1; period = 8'd2; count = 8'd10;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if ({strobe_out, busy, done} !== {exp_strobe, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL rst_pre_model cyc=%0d sbd got=%b exp=%b", i, {strobe_out, busy, done}, {exp_strobe, exp_busy, exp_done});
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({strobe_out, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL rst_async got=%b exp=000", {strobe_out, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if ({strobe_out, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_post_idle cyc=%0d got=%b exp=000", i, {strobe_out, busy, done});
         end
      end
      test_basic_burst();
   endtask

   task automatic test_back_to_back();
      int n_done = 0;
      logic prev_done = 1'b0;
      @(negedge clk);
      start = 1'b1; period = 8'($urandom_range(0, 3)); count = 8'($urandom_range(1, 3));
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         period = 8'($urandom_range(0, 3)); count = 8'($urandom_range(1, 3));
         checks++;
         if ({strobe_out, busy, done} !== {exp_strobe, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL b2b_model cyc=%0d sbd got=%b exp=%b", i, {strobe_out, busy, done}, {exp_strobe, exp_busy, exp_done});
         end
         if (prev_done) begin
            checks++;
            if ({strobe_out, busy} !== 2'b11) begin
               errors++;
               $display("FAIL b2b_restart cyc=%0d got sb=%b exp=11", i, {strobe_out, busy});
            end
         end
         prev_done = done;
         if (done) n_done++;
      end
      start = 1'b0;
      checks++;
      if (n_done < 5) begin
         errors++;
         $display("FAIL b2b_done_count got=%0d exp>=5", n_done);
      end
   endtask

   task automatic test_random();
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         checks++;
         if ({strobe_out, busy, done} !== {exp_strobe, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL rand_model cyc=%0d sbd got=%b exp=%b", i, {strobe_out, busy, done}, {exp_strobe, exp_busy, exp_done});
         end
         checks++;
         if (strobe_out && done) begin
            errors++;
            $display("FAIL rand_strobe_done cyc=%0d got both=1 exp not both", i);
         end
`ifdef STROBE_GEN_COUNT_OUT_EN
         checks++;
         if (strobes_sent !== m_sent) begin
            errors++;
            $display("FAIL rand_sent cyc=%0d got=%0d exp=%0d", i, strobes_sent, m_sent);
         end
`endif
         start = ($urandom_range(0, 2) == 0);
         abort = ($urandom_range(0, 15) == 0);
         period = 8'($urandom_range(0, 6));
         count = 8'($urandom_range(0, 5));
      end
      start = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

`ifdef STROBE_GEN_COUNT_OUT_EN
   task automatic test_wrap();
      @(negedge clk);
      start = 1'b1; period = 8'd1; count = 8'd0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (strobes_sent !== CW'((i - 1) % 256)) begin
            errors++;
            $display("FAIL wrap_sent cyc=%0d got=%0d exp=%0d", i, strobes_sent, (i - 1) % 256);
         end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic_burst();
      test_period_zero();
      test_free_run_abort();
      test_start_abort_idle();
      test_abort_last();
      test_async_reset();
      test_back_to_back();
      test_random();
`ifdef STROBE_GEN_COUNT_OUT_EN
      test_wrap();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
